// File: rtl/vga_timing_controller.sv
// vga_timing_controller
//   Generates VGA raster timing (default 640x480 @ 60 Hz from a 50 MHz clock)
//   and sequences the video generator. It presents pixel coordinates x/y to
//   the generator, then registers the returned colour together with the
//   sync/blank terms, so colour and syncs leave on the same pixel tick.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high; clears counters and output stage
//   pix_en       one-clk pixel tick strobe (every CLK_DIV clocks)
//   x, y         current horizontal / vertical counter values (10 bits)
//   r_in..b_in   generator colour for the current x, y
//   vga_r..vga_b registered colour to the DAC (zero outside the active area)
//   hsync, vsync active-low syncs, delayed one tick to align with colour
//   blank_n      high while the registered pixel is in the active area
//   sync_n       constant 0 (no sync-on-green)
//   frame_start  one-clk pulse on the tick that presents pixel (0,0)
module vga_timing_controller #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              pix_en,
  output logic [9:0]        x,
  output logic [9:0]        y,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] g_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] vga_r,
  output logic [DATA_W-1:0] vga_g,
  output logic [DATA_W-1:0] vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              sync_n,
  output logic              frame_start
);

  localparam int CNT_W = 10;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Counters are 10 bits wide; larger rasters would silently alias.
  if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1) begin : g_param_check
    $error("vga_timing_controller: H_TOT/V_TOT must be <= 1024 and CLK_DIV >= 1");
  end

  // Colour is forced to black outside the active area.
  function automatic logic [DATA_W-1:0] gate_colour(input logic [DATA_W-1:0] c,
                                                    input logic en);
    return en ? c : '0;
  endfunction

  logic [DIV_W-1:0]  div_p0;
  logic [CNT_W-1:0]  hcnt_p0;
  logic [CNT_W-1:0]  vcnt_p0;
  logic              tick;
  logic              line_end;
  logic              active_p0;
  logic              hs_p0;
  logic              vs_p0;

  logic [DATA_W-1:0] r_p1;
  logic [DATA_W-1:0] g_p1;
  logic [DATA_W-1:0] b_p1;
  logic              hs_p1;
  logic              vs_p1;
  logic              vld_p1;

  // ---- stage 0: clock divider and raster counters ----
  // The tick is masked during reset so nothing downstream sees a strobe
  // while the counters are being cleared.
  assign tick     = (div_p0 == DIV_LAST) && !reset;
  assign line_end = (hcnt_p0 == H_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_p0 <= '0;
    end else if (div_p0 == DIV_LAST) begin
      div_p0 <= '0;
    end else begin
      div_p0 <= div_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= '0;
    end else if (tick) begin
      hcnt_p0 <= line_end ? '0 : hcnt_p0 + 1'b1;
      if (line_end) begin
        vcnt_p0 <= (vcnt_p0 == V_LAST) ? '0 : vcnt_p0 + 1'b1;
      end
    end
  end

  assign active_p0 = (hcnt_p0 < H_ACT_C) && (vcnt_p0 < V_ACT_C);
  assign hs_p0     = !((hcnt_p0 >= HS_BEG) && (hcnt_p0 < HS_END));
  assign vs_p0     = !((vcnt_p0 >= VS_BEG) && (vcnt_p0 < VS_END));

  // ---- stage 1: output register, loaded once per pixel tick ----
  // Syncs travel through the same register as colour, so the one-tick
  // generator latency applies equally to both.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      vld_p1 <= 1'b0;
    end else if (tick) begin
      r_p1   <= gate_colour(r_in, active_p0);
      g_p1   <= gate_colour(g_in, active_p0);
      b_p1   <= gate_colour(b_in, active_p0);
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      vld_p1 <= active_p0;
    end
  end

  assign pix_en      = tick;
  assign x           = hcnt_p0;
  assign y           = vcnt_p0;
  assign vga_r       = r_p1;
  assign vga_g       = g_p1;
  assign vga_b       = b_p1;
  assign hsync       = hs_p1;
  assign vsync       = vs_p1;
  assign blank_n     = vld_p1;
  assign sync_n      = 1'b0;
  assign frame_start = tick && (hcnt_p0 == '0) && (vcnt_p0 == '0);

endmodule

// File: tb/tb_vga_timing_controller.sv
// Testbench for vga_timing_controller. Three instances share clock and reset:
//   cfg0  default 640x480 raster, CLK_DIV=2
//   cfg1  default 640x480 raster, CLK_DIV=4
//   cfg2  small raster (32x13 totals), CLK_DIV=2, so whole frames fit the run
// A reference model derives every expected value from the count of clock
// edges since reset using plain division/modulo of the raster rules. On each
// pixel tick it predicts, the model pushes the expected output word into a
// queue; a monitor pops it when the DUT strobes pix_en and compares after
// the following edge. Sync widths, periods and frame spacing are measured too.
module tb_vga_timing_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seed_r, seed_g, seed_b;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bl;
  } exp_t;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input int g, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %0d expected %0d (cycle %0d)", g, nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int CD  = (g == 1) ? 4 : 2;
    localparam int HA  = (g == 2) ? 20 : 640;
    localparam int HFP = (g == 2) ? 3  : 16;
    localparam int HS  = (g == 2) ? 5  : 96;
    localparam int HBP = (g == 2) ? 4  : 48;
    localparam int VA  = (g == 2) ? 6  : 480;
    localparam int VFP = (g == 2) ? 2  : 10;
    localparam int VS  = 2;
    localparam int VBP = (g == 2) ? 3  : 33;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    logic       pix_en, hsync, vsync, blank_n, sync_n, frame_start;
    logic [9:0] x, y;
    logic [7:0] r_in, g_in, b_in, vga_r, vga_g, vga_b;

    assign r_in = x[7:0] ^ seed_r;
    assign g_in = seed_g;
    assign b_in = y[7:0] ^ seed_b;

    vga_timing_controller #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .DATA_W(8)
    ) dut (
      .clk(clk), .reset(rst), .pix_en(pix_en), .x(x), .y(y),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
      .frame_start(frame_start)
    );

    int   kk       = 0;
    logic rst_edge = 1'b0;
    logic pe_seen  = 1'b0;
    exp_t q[$];
    int   last_rst = 0;
    int   h_fall   = -1;
    int   v_fall   = -1;
    int   x0       = -1;
    int   fs_last  = -1;

    // Edges since the most recent reset edge.
    initial forever begin
      @(posedge clk);
      rst_edge = rst;
      if (rst) kk = 0;
      else kk++;
    end

    // Reference model: coordinates/strobes now, and the output word that the
    // next edge must load when a tick is due.
    initial begin : model
      int   n, ex, ey;
      logic ep, act;
      exp_t e;
      forever begin
        @(negedge clk);
        ep = !rst && (kk % CD == CD - 1);
        n  = kk / CD;
        ex = n % HT;
        ey = (n / HT) % VT;
        check(g, "pix_en", pix_en, ep);
        check(g, "x", x, ex);
        check(g, "y", y, ey);
        check(g, "frame_start", frame_start, ep && ex == 0 && ey == 0);
        if (frame_start === 1'b1) begin
          if (fs_last > last_rst) check(g, "frame_period", cyc - fs_last, VT * HT * CD);
          fs_last = cyc;
        end
        if (ep) begin
          act  = (ex < HA) && (ey < VA);
          e.r  = act ? (8'(ex) ^ seed_r) : 8'h00;
          e.g  = act ? seed_g : 8'h00;
          e.b  = act ? (8'(ey) ^ seed_b) : 8'h00;
          e.hs = !((ex >= HA + HFP) && (ex < HA + HFP + HS));
          e.vs = !((ey >= VA + VFP) && (ey < VA + VFP + VS));
          e.bl = act;
          q.push_back(e);
        end
      end
    end

    initial forever begin
      @(negedge clk);
      pe_seen = pix_en;
    end

    // Monitor: pops on every DUT tick, checks reset values, measures syncs.
    initial begin : monitor
      exp_t       e;
      logic       prev_hs = 1'b1;
      logic       prev_vs = 1'b1;
      logic [9:0] prev_x  = '0;
      forever begin
        @(posedge clk);
        #1;
        if (rst_edge) begin
          last_rst = cyc;
          check(g, "rst_vga_r", vga_r, 0);
          check(g, "rst_vga_g", vga_g, 0);
          check(g, "rst_vga_b", vga_b, 0);
          check(g, "rst_hsync", hsync, 1);
          check(g, "rst_vsync", vsync, 1);
          check(g, "rst_blank_n", blank_n, 0);
          check(g, "sync_n", sync_n, 0);
          q.delete();
        end else if (pe_seen) begin
          check(g, "sb_depth", q.size(), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check(g, "vga_r", vga_r, e.r);
            check(g, "vga_g", vga_g, e.g);
            check(g, "vga_b", vga_b, e.b);
            check(g, "hsync", hsync, e.hs);
            check(g, "vsync", vsync, e.vs);
            check(g, "blank_n", blank_n, e.bl);
          end
        end
        check(g, "sb_backlog", q.size(), 0);

        if (x == 10'd0 && (rst_edge || prev_x != 10'd0)) x0 = cyc;
        if (prev_hs && !hsync) begin
          if (x0 >= last_rst) check(g, "hs_fall_offset", cyc - x0, (HA + HFP + 1) * CD);
          if (h_fall > last_rst) check(g, "hs_period", cyc - h_fall, HT * CD);
          h_fall = cyc;
        end
        if (!prev_hs && hsync && h_fall > last_rst) check(g, "hs_width", cyc - h_fall, HS * CD);
        if (prev_vs && !vsync) begin
          if (v_fall > last_rst) check(g, "vs_period", cyc - v_fall, VT * HT * CD);
          v_fall = cyc;
        end
        if (!prev_vs && vsync && v_fall > last_rst) check(g, "vs_width", cyc - v_fall, VS * HT * CD);
        prev_hs = hsync;
        prev_vs = vsync;
        prev_x  = x;
      end
    end
  end

  // Stimulus: power-on reset, a long undisturbed run with the plain colour
  // pattern, random colour seeds, random mid-frame resets, a final run.
  initial begin
    rst    = 1'b1;
    seed_r = 8'h00;
    seed_g = 8'hAA;
    seed_b = 8'h00;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    repeat (5000) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #3;
      seed_r = 8'($urandom);
      seed_g = 8'($urandom);
      seed_b = 8'($urandom);
      repeat (500) @(posedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(200, 2500)) @(posedge clk);
      #3 rst = 1'b1;
      repeat ((i == 3) ? 3 : 1) @(posedge clk);
      #3;
      rst    = 1'b0;
      seed_r = 8'($urandom);
      seed_b = 8'($urandom);
    end
    repeat (3500) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
